pe_feeder: RTL
==============

Name: pe_feeder

Overview:
- Sequencer that drives one 3-lane multiply-accumulate PE and collects its result.
- Reads packed IFM and weight words from two synchronous-read buffers and presents one 3-pair group per cycle on the PE input ports.
- Frames the accumulation with the PE clear (pe_en) and finish (pe_finish) controls, then captures the PE's 8-bit OFM on its valid pulse.
- Returns the result to the layer controller over a valid/ready handshake.

Parameters:
ADDR_W, 10, buffer address width (IFM and weight buffers)
CNT_W, 8, width of group count n_groups

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  command request; accepted when start && start_ready
start_ready  out  1  high only in IDLE
ifm_base  in  ADDR_W  first IFM word address, sampled on accept
wgt_base  in  ADDR_W  first weight word address, sampled on accept
n_groups  in  CNT_W  number of 3-pair groups to accumulate, sampled on accept
ifm_rd_en  out  1  IFM buffer read strobe
ifm_addr  out  ADDR_W  IFM read address
ifm_rd_data  in  24  IFM word, valid the cycle after ifm_rd_en; [7:0]=lane1, [15:8]=lane2, [23:16]=lane3
wgt_rd_en  out  1  weight buffer read strobe
wgt_addr  out  ADDR_W  weight read address
wgt_rd_data  in  24  weight word, same timing and packing as IFM
pe_ifm1, pe_ifm2, pe_ifm3  out  8 each  PE IFM lanes
pe_weight1, pe_weight2, pe_weight3  out  8 each  PE weight lanes
pe_en  out  1  PE accumulator clear; high = PE clears
pe_finish  out  1  PE finish strobe
pe_ofm  in  8  PE accumulator value
pe_valid  in  1  PE valid pulse, one cycle after pe_finish
res_data  out  8  captured OFM
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
busy  out  1  high in any state but IDLE
err  out  1  sticky protocol error; cleared only by reset

Behaviour:
- Reset values:
  - pe_en=1.
  - All other outputs 0, except start_ready=1 (IDLE).
  - Reset mid-operation aborts immediately: reads stop and pe_en returns to 1, so the PE stays cleared.
- Every PE-side output is a register.
- The PE accumulates on every cycle with pe_en=0, so:
  - pe_en=0 exactly in cycles where a valid group is on the pe_ifm/pe_weight ports; pe_en=1 otherwise.
  - All lanes read 0 whenever pe_en=1.
- States: IDLE, READ, DRAIN, WAIT_PE, RESULT.
- IDLE:
  - On accept with n_groups>0: latch the bases and the count, go to READ.
  - On accept with n_groups=0: go to RESULT with res_data=0; no reads are issued and the PE is untouched.
- READ:
  - For n consecutive cycles: ifm_rd_en=wgt_rd_en=1, addresses base+i for i=0..n-1.
  - Addresses wrap modulo 2^ADDR_W.
  - Go to DRAIN after the last read.
- Data path: rd_data is registered onto the PE ports the cycle after it returns. Group i is therefore on the PE ports 2 cycles after its read cycle, with pe_en=0.
- pe_finish=1 in the same cycle as group n-1 only.
- DRAIN: wait for the last group to leave the pipeline, then go to WAIT_PE.
- WAIT_PE:
  - pe_valid is expected in the cycle after the pe_finish cycle.
  - When it arrives, capture pe_ofm into res_data and go to RESULT.
  - If pe_valid is absent in that cycle: set err, load res_data=0, go to RESULT.
- RESULT: res_valid=1 and res_data held stable until res_ready=1. Go to IDLE on that edge.
- Timing for n>0:
  - Accept at cycle 0; reads in cycles 1..n.
  - Groups on the PE in cycles 3..n+2.
  - pe_valid in cycle n+3.
  - res_valid first high in cycle n+4.
- Arithmetic: none in this block. The result equals the PE's 8-bit wrapping sum, mod 256.
- start is ignored outside IDLE, including while RESULT is stalled on res_ready.
- pe_valid=1 in any cycle other than the expected one sets err; the result already captured is unaffected.

Test Plan:
- n_groups=1, ifm word 0x030201, wgt word 0x060504, PE model attached -> pe_en low one cycle (cycle 3), pe_finish coincident, res_data=0x20 with res_valid in cycle 5, err=0.
- n_groups=4, all four word pairs as above, ifm_base=0x3FE -> addresses 0x3FE, 0x3FF, 0x000, 0x001; res_data=0x80.
- n_groups=3, ifm=0xFFFFFF, wgt=0x010101 -> sum 9×255 mod 256 = 0xF7; confirms wrap is inherited from the PE.
- res_ready held low 10 cycles and start pulsed during the stall -> res_data/res_valid stable, start_ready=0, no new reads; next accept proceeds normally.
- n_groups=0 -> no rd_en, pe_en stays 1, res_data=0 in cycle 1.
- Reset asserted in cycle 2 of a 5-group job -> pe_en=1, rd_en=0, start_ready=1 immediately. Spurious pe_valid injected while IDLE -> err=1, held until reset.

Source files
------------

// File: rtl/pe_feeder.sv
// Sequencer that streams packed IFM/weight words from two buffers into a 3-lane MAC PE,
// frames the accumulation with pe_en/pe_finish and hands the PE result back over valid/ready.

module pe_feeder_lane #(
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [VEC_W-1:0] ifm_in,
    input  logic [VEC_W-1:0] wgt_in,
    output logic [VEC_W-1:0] ifm_out,
    output logic [VEC_W-1:0] wgt_out
);
    // Lanes read zero whenever no valid group is presented, so the PE sees clean inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifm_out <= '0;
            wgt_out <= '0;
        end else if (load) begin
            ifm_out <= ifm_in;
            wgt_out <= wgt_in;
        end else begin
            ifm_out <= '0;
            wgt_out <= '0;
        end
    end
endmodule

module pe_feeder #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              start_ready,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [CNT_W-1:0]  n_groups,
    output logic              ifm_rd_en,
    output logic [ADDR_W-1:0] ifm_addr,
    input  logic [23:0]       ifm_rd_data,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic [23:0]       wgt_rd_data,
    output logic [7:0]        pe_ifm1,
    output logic [7:0]        pe_ifm2,
    output logic [7:0]        pe_ifm3,
    output logic [7:0]        pe_weight1,
    output logic [7:0]        pe_weight2,
    output logic [7:0]        pe_weight3,
    output logic              pe_en,
    output logic              pe_finish,
    input  logic [7:0]        pe_ofm,
    input  logic              pe_valid,
    output logic [7:0]        res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              err
);
    localparam int NUM_LANES = 3;
    localparam int VEC_W     = 8;
    localparam int STAGES    = 1;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_PE, RESULT} state_t;

    state_t                              state;
    logic [CNT_W-1:0]                    cnt;
    logic [STAGES:0]                     vld_pipe;
    logic [STAGES:0]                     last_pipe;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_ifm;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_wgt;

    // vld_pipe[0] is the read strobe itself; vld_pipe[STAGES] marks returned data.
    assign ifm_rd_en = vld_pipe[0];
    assign wgt_rd_en = vld_pipe[0];

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            pe_feeder_lane #(.VEC_W(VEC_W)) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (vld_pipe[STAGES]),
                .ifm_in  (ifm_rd_data[l*VEC_W +: VEC_W]),
                .wgt_in  (wgt_rd_data[l*VEC_W +: VEC_W]),
                .ifm_out (lane_ifm[l]),
                .wgt_out (lane_wgt[l])
            );
        end
    endgenerate

    assign pe_ifm1    = lane_ifm[0];
    assign pe_ifm2    = lane_ifm[1];
    assign pe_ifm3    = lane_ifm[2];
    assign pe_weight1 = lane_wgt[0];
    assign pe_weight2 = lane_wgt[1];
    assign pe_weight3 = lane_wgt[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            ifm_addr    <= '0;
            wgt_addr    <= '0;
            cnt         <= '0;
            vld_pipe    <= '0;
            last_pipe   <= '0;
            pe_en       <= 1'b1;
            pe_finish   <= 1'b0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
            last_pipe[STAGES:1] <= last_pipe[STAGES-1:0] & vld_pipe[STAGES-1:0];
            pe_en               <= !vld_pipe[STAGES];
            pe_finish           <= vld_pipe[STAGES] && last_pipe[STAGES];

            // WAIT_PE lasts exactly one cycle, the only slot where pe_valid is legal.
            if (pe_valid && state != WAIT_PE)
                err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (n_groups == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= RESULT;
                        end else begin
                            ifm_addr     <= ifm_base;
                            wgt_addr     <= wgt_base;
                            cnt          <= n_groups - CNT_W'(1);
                            vld_pipe[0]  <= 1'b1;
                            last_pipe[0] <= (n_groups == CNT_W'(1));
                            state        <= READ;
                        end
                    end
                end
                READ: begin
                    // cnt counts reads still to issue after the current one.
                    if (cnt == '0) begin
                        vld_pipe[0]  <= 1'b0;
                        last_pipe[0] <= 1'b0;
                        state        <= DRAIN;
                    end else begin
                        ifm_addr     <= ifm_addr + ADDR_W'(1);
                        wgt_addr     <= wgt_addr + ADDR_W'(1);
                        cnt          <= cnt - CNT_W'(1);
                        last_pipe[0] <= (cnt == CNT_W'(1));
                    end
                end
                DRAIN: begin
                    if (pe_finish)
                        state <= WAIT_PE;
                end
                WAIT_PE: begin
                    res_data  <= pe_valid ? pe_ofm : 8'h00;
                    res_valid <= 1'b1;
                    if (!pe_valid)
                        err <= 1'b1;
                    state <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
